// File: rtl/uart_bus_regs.sv
// Bus register front end for the uart core: DATA/STATUS/CTRL/divisor registers,
// RX occupancy tracking with overrun detection, TX overflow flag and a level IRQ.
module uart_bus_regs #(
   parameter int unsigned FIFO_W   = 2,
   parameter int unsigned DVSR_RST = 324
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        irq,
   output logic        rd_uart,
   output logic        wr_uart,
   output logic [7:0]  w_data,
   output logic [20:0] dvsr,
   input  logic [7:0]  r_data,
   input  logic        rx_empty,
   input  logic        tx_full,
   input  logic        rx_done_tick
);

   localparam int unsigned CntW = FIFO_W + 1;
   localparam logic [CntW-1:0] RxDepth = CntW'(2 ** FIFO_W);

   localparam logic [2:0] AddrData   = 3'd0;
   localparam logic [2:0] AddrStatus = 3'd1;
   localparam logic [2:0] AddrCtrl   = 3'd2;
   localparam logic [2:0] AddrDiv0   = 3'd3;
   localparam logic [2:0] AddrDiv1   = 3'd4;
   localparam logic [2:0] AddrDiv2   = 3'd5;

   logic            rd_acc, wr_acc, status_rd;
   logic            rx_inc, rx_dec, rx_full;
   logic            ovr_set, txovf_set;

   logic [7:0]      rdata_q, rdata_d;
   logic            irq_q, irq_d;
   logic [20:0]     dvsr_q, dvsr_d;
   logic [2:0]      ctrl_q, ctrl_d;
   logic [7:0]      sh0_q, sh0_d, sh1_q, sh1_d;
   logic            ovr_q, ovr_d, txovf_q, txovf_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;

   assign rd_acc    = cs & ~we;
   assign wr_acc    = cs & we;
   assign status_rd = rd_acc & (addr == AddrStatus);

   assign rd_uart = rd_acc & (addr == AddrData) & ~rx_empty;
   assign wr_uart = wr_acc & (addr == AddrData) & ~tx_full;
   assign w_data  = wdata;

   // A simultaneous push and pop leaves occupancy unchanged, so no overrun then.
   assign rx_inc    = rx_done_tick & ~rd_uart;
   assign rx_dec    = rd_uart & ~rx_done_tick;
   assign rx_full   = (rx_cnt_q == RxDepth);
   assign ovr_set   = rx_inc & rx_full;
   assign txovf_set = wr_acc & (addr == AddrData) & tx_full;

   assign rdata = rdata_q;
   assign irq   = irq_q;
   assign dvsr  = dvsr_q;

   always_comb begin
      rx_cnt_d = rx_cnt_q;
      if (rx_inc && !rx_full) begin
         rx_cnt_d = rx_cnt_q + CntW'(1);
      end else if (rx_dec && (rx_cnt_q != '0)) begin
         rx_cnt_d = rx_cnt_q - CntW'(1);
      end

      // Set events beat the clear-on-read of STATUS.
      ovr_d   = ovr_set | (ovr_q & ~status_rd);
      txovf_d = txovf_set | (txovf_q & ~status_rd);

      ctrl_d = ctrl_q;
      sh0_d  = sh0_q;
      sh1_d  = sh1_q;
      dvsr_d = dvsr_q;
      if (wr_acc) begin
         case (addr)
            AddrCtrl: ctrl_d = wdata[2:0];
            AddrDiv0: sh0_d  = wdata;
            AddrDiv1: sh1_d  = wdata;
            AddrDiv2: dvsr_d = {wdata[4:0], sh1_q, sh0_q};
            default:  ;
         endcase
      end

      rdata_d = rdata_q;
      if (rd_acc) begin
         case (addr)
            AddrData:   rdata_d = rx_empty ? 8'h00 : r_data;
            AddrStatus: rdata_d = {irq_q, 3'b000, txovf_q, ovr_q, tx_full, ~rx_empty};
            AddrCtrl:   rdata_d = {5'b00000, ctrl_q};
            AddrDiv0:   rdata_d = dvsr_q[7:0];
            AddrDiv1:   rdata_d = dvsr_q[15:8];
            AddrDiv2:   rdata_d = {3'b000, dvsr_q[20:16]};
            default:    rdata_d = 8'h00;
         endcase
      end

      irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & ~tx_full) | (ctrl_q[2] & (ovr_q | txovf_q));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q  <= 8'h00;
         irq_q    <= 1'b0;
         dvsr_q   <= 21'(DVSR_RST);
         ctrl_q   <= 3'b000;
         sh0_q    <= 8'h00;
         sh1_q    <= 8'h00;
         ovr_q    <= 1'b0;
         txovf_q  <= 1'b0;
         rx_cnt_q <= '0;
      end else begin
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
         dvsr_q   <= dvsr_d;
         ctrl_q   <= ctrl_d;
         sh0_q    <= sh0_d;
         sh1_q    <= sh1_d;
         ovr_q    <= ovr_d;
         txovf_q  <= txovf_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_bus_regs.sv
// Directed and randomized bench for uart_bus_regs against a behavioural register model.
module tb_uart_bus_regs;

   localparam int FIFO_W   = 2;
   localparam int DEPTH    = 4;
   localparam int DVSR_RST = 324;

   logic        clk = 1'b0;
   logic        reset, cs, we, rx_empty, tx_full, rx_done_tick;
   logic [2:0]  addr;
   logic [7:0]  wdata, r_data;
   logic [7:0]  rdata, w_data;
   logic        irq, rd_uart, wr_uart;
   logic [20:0] dvsr;

   int checks = 0;
   int failures = 0;

   // Model state
   logic [7:0]  m_rdata, m_sh0, m_sh1;
   logic [2:0]  m_ctrl;
   logic [20:0] m_dvsr;
   logic        m_irq, m_ovr, m_txovf;
   int          m_cnt;

   // Last sampled combinational strobes
   logic        got_rdu, got_wru;

   uart_bus_regs #(
      .FIFO_W   (FIFO_W),
      .DVSR_RST (DVSR_RST)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cs           (cs),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata),
      .irq          (irq),
      .rd_uart      (rd_uart),
      .wr_uart      (wr_uart),
      .w_data       (w_data),
      .dvsr         (dvsr),
      .r_data       (r_data),
      .rx_empty     (rx_empty),
      .tx_full      (tx_full),
      .rx_done_tick (rx_done_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus cycle: drive, check strobes, advance the model across the edge, check registers.
   task automatic step(input logic r, input logic c, input logic w, input logic [2:0] a,
                       input logic [7:0] d, input logic t);
      logic       rd, wr, e_rdu, e_wru, stat_rd, ovr_set, txovf_set;
      logic [7:0] n_rdata;
      logic       n_irq;
      reset = r; cs = c; we = w; addr = a; wdata = d; rx_done_tick = t;
      #1;
      rd    = c && !w;
      wr    = c && w;
      e_rdu = rd && (a == 3'd0) && !rx_empty;
      e_wru = wr && (a == 3'd0) && !tx_full;
      got_rdu = rd_uart;
      got_wru = wr_uart;
      chk("rd_uart", 32'(rd_uart), 32'(e_rdu));
      chk("wr_uart", 32'(wr_uart), 32'(e_wru));
      if (e_wru) chk("w_data", 32'(w_data), 32'(d));

      if (r) begin
         m_rdata = 8'h00; m_irq = 1'b0; m_dvsr = 21'(DVSR_RST); m_ctrl = 3'b000;
         m_sh0 = 8'h00; m_sh1 = 8'h00; m_ovr = 1'b0; m_txovf = 1'b0; m_cnt = 0;
      end else begin
         n_rdata = m_rdata;
         if (rd) begin
            case (a)
               3'd0: n_rdata = rx_empty ? 8'h00 : r_data;
               3'd1: n_rdata = {m_irq, 3'b000, m_txovf, m_ovr, tx_full, !rx_empty};
               3'd2: n_rdata = {5'b0, m_ctrl};
               3'd3: n_rdata = m_dvsr[7:0];
               3'd4: n_rdata = m_dvsr[15:8];
               3'd5: n_rdata = {3'b000, m_dvsr[20:16]};
               default: n_rdata = 8'h00;
            endcase
         end
         n_irq = (m_ctrl[0] && !rx_empty) || (m_ctrl[1] && !tx_full) ||
                 (m_ctrl[2] && (m_ovr || m_txovf));
         ovr_set = 1'b0;
         if (t && !e_rdu) begin
            if (m_cnt == DEPTH) ovr_set = 1'b1;
            else m_cnt = m_cnt + 1;
         end else if (e_rdu && !t) begin
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
         end
         stat_rd   = rd && (a == 3'd1);
         txovf_set = wr && (a == 3'd0) && tx_full;
         m_ovr   = ovr_set ? 1'b1 : (stat_rd ? 1'b0 : m_ovr);
         m_txovf = txovf_set ? 1'b1 : (stat_rd ? 1'b0 : m_txovf);
         if (wr) begin
            case (a)
               3'd2: m_ctrl = d[2:0];
               3'd3: m_sh0 = d;
               3'd4: m_sh1 = d;
               3'd5: m_dvsr = {d[4:0], m_sh1, m_sh0};
               default: ;
            endcase
         end
         m_rdata = n_rdata;
         m_irq   = n_irq;
      end

      @(posedge clk);
      #1;
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("dvsr", 32'(dvsr), 32'(m_dvsr));
      cs = 1'b0; rx_done_tick = 1'b0; reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00;
      r_data = 8'h00; rx_empty = 1'b1; tx_full = 1'b0; rx_done_tick = 1'b0;
      @(posedge clk);
      #1;
      step(1, 0, 0, 3'd0, 8'h00, 0);
      step(1, 0, 0, 3'd0, 8'h00, 0);

      // Reset values
      step(0, 1, 0, 3'd1, 8'h00, 0); chk("tp_status_rst", 32'(rdata), 32'h00);
      step(0, 1, 0, 3'd3, 8'h00, 0); chk("tp_div0_rst", 32'(rdata), 32'h44);
      step(0, 1, 0, 3'd4, 8'h00, 0); chk("tp_div1_rst", 32'(rdata), 32'h01);
      step(0, 1, 0, 3'd5, 8'h00, 0); chk("tp_div2_rst", 32'(rdata), 32'h00);
      chk("tp_irq_rst", 32'(irq), 32'h0);

      // Shadowed divisor update
      step(0, 1, 1, 3'd3, 8'h0A, 0);
      step(0, 1, 1, 3'd4, 8'h00, 0); chk("tp_dvsr_shadow", 32'(dvsr), 32'd324);
      step(0, 1, 1, 3'd5, 8'h00, 0); chk("tp_dvsr_load", 32'(dvsr), 32'd10);
      step(0, 1, 0, 3'd3, 8'h00, 0); chk("tp_div0_read", 32'(rdata), 32'h0A);

      // TX write while full
      tx_full = 1'b1;
      step(0, 1, 1, 3'd0, 8'h55, 0); chk("tp_wr_drop", 32'(got_wru), 32'h0);
      step(0, 1, 0, 3'd1, 8'h00, 0); chk("tp_txovf_status", 32'(rdata), 32'h0A);
      step(0, 1, 0, 3'd1, 8'h00, 0); chk("tp_txovf_clear", 32'(rdata), 32'h02);
      tx_full = 1'b0;

      // RX overrun: 5 pushes into a 4-deep FIFO
      for (int i = 0; i < 5; i++) step(0, 0, 0, 3'd0, 8'h00, 1);
      step(0, 1, 0, 3'd1, 8'h00, 0); chk("tp_ovr_set", 32'(rdata), 32'h04);
      rx_empty = 1'b0; r_data = 8'h33;
      step(0, 1, 0, 3'd0, 8'h00, 1); chk("tp_pop_push_data", 32'(rdata), 32'h33);
      step(0, 0, 0, 3'd0, 8'h00, 1);
      step(0, 1, 0, 3'd1, 8'h00, 0); chk("tp_cnt_held_full", 32'(rdata), 32'h05);
      step(0, 1, 0, 3'd1, 8'h00, 0); chk("tp_ovr_clear", 32'(rdata), 32'h01);

      // RX interrupt and data pop
      r_data = 8'h41;
      step(0, 1, 1, 3'd2, 8'h01, 0); chk("tp_irq_lag", 32'(irq), 32'h0);
      step(0, 0, 0, 3'd0, 8'h00, 0); chk("tp_irq_rx", 32'(irq), 32'h1);
      step(0, 1, 0, 3'd0, 8'h00, 0);
      chk("tp_rd_pulse", 32'(got_rdu), 32'h1);
      chk("tp_rd_data", 32'(rdata), 32'h41);
      rx_empty = 1'b1;
      step(0, 0, 0, 3'd0, 8'h00, 0); chk("tp_irq_drop", 32'(irq), 32'h0);
      step(0, 1, 0, 3'd0, 8'h00, 0);
      chk("tp_rd_empty_pulse", 32'(got_rdu), 32'h0);
      chk("tp_rd_empty_data", 32'(rdata), 32'h00);

      // Reset wins over a concurrent write; the push strobe is still combinational
      step(1, 1, 1, 3'd0, 8'h77, 0);
      chk("tp_rst_wr_pulse", 32'(got_wru), 32'h1);
      chk("tp_rst_dvsr", 32'(dvsr), 32'd324);
      chk("tp_rst_rdata", 32'(rdata), 32'h00);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic       rr, cc, ww, tt;
         logic [2:0] aa;
         rr = ($urandom_range(0, 63) == 0);
         cc = ($urandom_range(0, 3) != 0);
         ww = 1'($urandom_range(0, 1));
         aa = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
         tt = ($urandom_range(0, 2) == 0);
         rx_empty = ($urandom_range(0, 3) == 0);
         tx_full  = ($urandom_range(0, 3) == 0);
         r_data   = 8'($urandom);
         step(rr, cc, ww, aa, 8'($urandom), tt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
